pipelined_control_unit: RTL
===========================

// Module: pipelined_control_unit
// PURPOSE
//  Registered RV32I(+M) decode/control stage for the pipelined core: decodes a fetched instruction into
//  the ALU, immediate, memory and write-back selects, holds them in an output pipeline register, and
//  owns valid/ready handshakes, load-use bubbles, MDU busy stalls, flushes and illegal-instruction flagging.
//  Sits between fetch and execute; branch/jump resolution happens in execute from branch_type/is_jump.
// PARAMETERS
//  ENABLE_M      0  1 = decode M-extension (funct7=0000001, opcode 0110011); 0 = M ops are illegal
//  MDU_LATENCY   4  cycles in_ready stays low after an M op is accepted (non-pipelined divider), >=1
//  ALU_SEL_W     5  alu_select width; must be 5 when ENABLE_M=1, 4 or 5 otherwise
// PORTS
//  clk                   in   1          clock
//  rst_n                 in   1          synchronous reset, active-low
//  in_valid              in   1          fetch presents instruction
//  in_ready              out  1          stage accepts instruction this cycle
//  instruction           in   32         instruction word
//  flush                 in   1          execute redirect: kill held and incoming instruction
//  ex_load_valid         in   1          execute stage holds a load
//  ex_load_rd            in   5          destination of that load
//  out_valid             out  1          control bundle valid
//  out_ready             in   1          execute accepts bundle
//  rs1, rs2, rd          out  5 each     register indices
//  immediate_select      out  3          1 I, 2 S, 3 B, 4 U, 5 J, 0 none
//  a_select, b_select    out  1 each     0 rs1/rs2, 1 pc/imm
//  alu_select            out  ALU_SEL_W  0 add,1 sll,2 slt,3 sltu,4 xor,5 srl,6 or,7 and,12 sub,13 sra,
//                                        15 pass-B, 16..23 mul,mulh,mulhsu,mulhu,div,divu,rem,remu
//  register_write_enable out  1
//  memory_write_enable   out  4          sb 0001, sh 0011, sw 1111
//  memory_split_option   out  3          lw 0, lh 1, lhu 2, lb 3, lbu 4
//  write_back_select     out  2          00 memory, 01 alu, 10 pc+4
//  is_branch, is_jump    out  1 each     branch (funct3 in branch_type) / jal or jalr
//  branch_type           out  3          funct3 of branch
//  is_load, is_mdu       out  1 each
//  illegal               out  1          undefined encoding
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): all outputs 0, out_valid=0, busy counter 0; in_ready=0 while rst_n=0.
//  - accept = in_valid & in_ready; in_ready = rst_n & !flush & !hazard & (busy==0) & (!out_valid | out_ready).
//  - Latency 1: accepted instruction's bundle appears with out_valid=1 on the next cycle.
//  - Output register: if out_valid & !out_ready, all outputs hold stable (no change until handshake).
//    On out_valid & out_ready & !accept, out_valid drops to 0 next cycle.
//  - Load-use hazard: hazard = ex_load_valid & ex_load_rd!=0 & ((uses_rs1 & rs1==ex_load_rd) |
//    (uses_rs2 & rs2==ex_load_rd)); uses_rs1: R,I,load,store,branch,jalr; uses_rs2: R,store,branch.
//  - MDU stall: accepting is_mdu loads busy=MDU_LATENCY; decrements each cycle to 0; flush does not clear it.
//  - flush: out_valid=0 next cycle; nothing accepted that cycle; flush has priority over every other event.
//  - Illegal (unknown opcode, bad funct3/funct7, M op with ENABLE_M=0): bundle issued with illegal=1,
//    register_write_enable=0, memory_write_enable=0, is_branch=is_jump=0, alu_select=0.
//  - sub/sra need funct7=0100000 exactly; slli/srli need funct7=0000000, srai 0100000; others illegal.
//  - lui: b_select=1, alu 15; auipc, jal, branches: a_select=1, b_select=1; jalr: b_select=1, wb 10.
//  - rd forced 0 in bundle for store/branch; x0 destinations keep register_write_enable as decoded.
// STRUCTURE
//  - Package rv_ctrl_pkg: opcode constants, ALU/imm/wb/split code localparams, control-bundle struct.
//  - Sub-module rv_decode_comb: pure combinational instruction -> bundle + uses_rs1/uses_rs2; one instance.
//  - Top: hazard logic, MDU busy counter, output register, handshake.
// TESTING
//  1 0x002081B3 (add x3,x1,x2), out_ready=1 -> next cycle out_valid=1, alu 0, wb 01, rwe 1, rd 3.
//  2 0x402081B3 (sub) -> alu 12; 0x FE208 1B3-style funct7=1111111 -> illegal=1, rwe 0.
//  3 0x0000A283 (lw x5) accepted; next 0x00028333 with ex_load_valid=1, ex_load_rd=5 -> in_ready=0
//    that cycle; accepted one cycle later when ex_load_valid=0.
//  4 out_ready=0 for 3 cycles with valid bundle -> all outputs stable, in_ready=0; release -> one transfer.
//  5 ENABLE_M=1, 0x022081B3 (mul) -> alu 16, is_mdu 1, in_ready low exactly 4 cycles; ENABLE_M=0 -> illegal.
//  6 flush with out_valid=1 and in_valid=1 -> out_valid=0 next cycle, nothing accepted; rst_n=0 mid-stall
//    -> all outputs 0, busy cleared.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - opcode, select-code and control-bundle definitions for the decode stage
package rv_ctrl_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   localparam logic [2:0] IMM_NONE = 3'd0;
   localparam logic [2:0] IMM_I    = 3'd1;
   localparam logic [2:0] IMM_S    = 3'd2;
   localparam logic [2:0] IMM_B    = 3'd3;
   localparam logic [2:0] IMM_U    = 3'd4;
   localparam logic [2:0] IMM_J    = 3'd5;

   localparam logic [4:0] ALU_ADD   = 5'd0;
   localparam logic [4:0] ALU_SLL   = 5'd1;
   localparam logic [4:0] ALU_SLT   = 5'd2;
   localparam logic [4:0] ALU_SLTU  = 5'd3;
   localparam logic [4:0] ALU_XOR   = 5'd4;
   localparam logic [4:0] ALU_SRL   = 5'd5;
   localparam logic [4:0] ALU_OR    = 5'd6;
   localparam logic [4:0] ALU_AND   = 5'd7;
   localparam logic [4:0] ALU_SUB   = 5'd12;
   localparam logic [4:0] ALU_SRA   = 5'd13;
   localparam logic [4:0] ALU_PASSB = 5'd15;
   localparam logic [4:0] ALU_MUL   = 5'd16;

   localparam logic [1:0] WB_MEM = 2'b00;
   localparam logic [1:0] WB_ALU = 2'b01;
   localparam logic [1:0] WB_PC4 = 2'b10;

   localparam logic [2:0] SPLIT_LW  = 3'd0;
   localparam logic [2:0] SPLIT_LH  = 3'd1;
   localparam logic [2:0] SPLIT_LHU = 3'd2;
   localparam logic [2:0] SPLIT_LB  = 3'd3;
   localparam logic [2:0] SPLIT_LBU = 3'd4;

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic [2:0] imm_sel;
      logic       a_sel;
      logic       b_sel;
      logic [4:0] alu_sel;
      logic       rwe;
      logic [3:0] mwe;
      logic [2:0] split;
      logic [1:0] wb_sel;
      logic       is_branch;
      logic       is_jump;
      logic [2:0] branch_type;
      logic       is_load;
      logic       is_mdu;
      logic       illegal;
   } ctrl_bundle_t;

   // Base integer ops share funct3 between OP and OP-IMM.
   function automatic logic [4:0] alu_of_funct3(input logic [2:0] f3);
      logic [4:0] code;
      case (f3)
         3'd0:    code = ALU_ADD;
         3'd1:    code = ALU_SLL;
         3'd2:    code = ALU_SLT;
         3'd3:    code = ALU_SLTU;
         3'd4:    code = ALU_XOR;
         3'd5:    code = ALU_SRL;
         3'd6:    code = ALU_OR;
         default: code = ALU_AND;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/rv_decode_comb.sv
// rtl/rv_decode_comb.sv - combinational RV32I(+M) instruction to control-bundle decoder
module rv_decode_comb
   import rv_ctrl_pkg::*;
#(
   parameter bit ENABLE_M = 1'b0
) (
   input  logic [31:0]  i_instruction,
   output ctrl_bundle_t o_bundle,
   output logic         o_uses_rs1,
   output logic         o_uses_rs2
);

   logic [6:0]   w_opcode;
   logic [2:0]   w_f3;
   logic [6:0]   w_f7;
   logic         w_legal;
   logic         w_u1;
   logic         w_u2;
   ctrl_bundle_t w_b;

   assign w_opcode = i_instruction[6:0];
   assign w_f3     = i_instruction[14:12];
   assign w_f7     = i_instruction[31:25];

   always_comb begin
      w_b         = '0;
      w_b.rs1     = i_instruction[19:15];
      w_b.rs2     = i_instruction[24:20];
      w_b.rd      = i_instruction[11:7];
      w_b.imm_sel = IMM_NONE;
      w_legal     = 1'b1;
      w_u1        = 1'b0;
      w_u2        = 1'b0;
      case (w_opcode)
         OPC_LUI: begin
            w_b.imm_sel = IMM_U;
            w_b.b_sel   = 1'b1;
            w_b.alu_sel = ALU_PASSB;
            w_b.rwe     = 1'b1;
            w_b.wb_sel  = WB_ALU;
         end
         OPC_AUIPC: begin
            w_b.imm_sel = IMM_U;
            w_b.a_sel   = 1'b1;
            w_b.b_sel   = 1'b1;
            w_b.rwe     = 1'b1;
            w_b.wb_sel  = WB_ALU;
         end
         OPC_JAL: begin
            w_b.imm_sel = IMM_J;
            w_b.a_sel   = 1'b1;
            w_b.b_sel   = 1'b1;
            w_b.rwe     = 1'b1;
            w_b.wb_sel  = WB_PC4;
            w_b.is_jump = 1'b1;
         end
         OPC_JALR: begin
            w_legal     = (w_f3 == 3'd0);
            w_b.imm_sel = IMM_I;
            w_b.b_sel   = 1'b1;
            w_b.rwe     = 1'b1;
            w_b.wb_sel  = WB_PC4;
            w_b.is_jump = 1'b1;
            w_u1        = 1'b1;
         end
         OPC_BRANCH: begin
            w_legal         = (w_f3 != 3'd2) && (w_f3 != 3'd3);
            w_b.imm_sel     = IMM_B;
            w_b.a_sel       = 1'b1;
            w_b.b_sel       = 1'b1;
            w_b.is_branch   = 1'b1;
            w_b.branch_type = w_f3;
            w_b.rd          = 5'd0;
            w_u1            = 1'b1;
            w_u2            = 1'b1;
         end
         OPC_LOAD: begin
            w_b.imm_sel = IMM_I;
            w_b.b_sel   = 1'b1;
            w_b.rwe     = 1'b1;
            w_b.wb_sel  = WB_MEM;
            w_b.is_load = 1'b1;
            w_u1        = 1'b1;
            case (w_f3)
               3'd0:    w_b.split = SPLIT_LB;
               3'd1:    w_b.split = SPLIT_LH;
               3'd2:    w_b.split = SPLIT_LW;
               3'd4:    w_b.split = SPLIT_LBU;
               3'd5:    w_b.split = SPLIT_LHU;
               default: w_legal   = 1'b0;
            endcase
         end
         OPC_STORE: begin
            w_b.imm_sel = IMM_S;
            w_b.b_sel   = 1'b1;
            w_b.rd      = 5'd0;
            w_u1        = 1'b1;
            w_u2        = 1'b1;
            case (w_f3)
               3'd0:    w_b.mwe = 4'b0001;
               3'd1:    w_b.mwe = 4'b0011;
               3'd2:    w_b.mwe = 4'b1111;
               default: w_legal = 1'b0;
            endcase
         end
         OPC_OPIMM: begin
            w_b.imm_sel = IMM_I;
            w_b.b_sel   = 1'b1;
            w_b.rwe     = 1'b1;
            w_b.wb_sel  = WB_ALU;
            w_b.alu_sel = alu_of_funct3(w_f3);
            w_u1        = 1'b1;
            // Shift-immediates reuse the funct7 field as an opcode extension.
            if (w_f3 == 3'd1) begin
               w_legal = (w_f7 == F7_BASE);
            end else if (w_f3 == 3'd5) begin
               if (w_f7 == F7_ALT) begin
                  w_b.alu_sel = ALU_SRA;
               end else if (w_f7 != F7_BASE) begin
                  w_legal = 1'b0;
               end
            end
         end
         OPC_OP: begin
            w_b.rwe    = 1'b1;
            w_b.wb_sel = WB_ALU;
            w_u1       = 1'b1;
            w_u2       = 1'b1;
            if (w_f7 == F7_BASE) begin
               w_b.alu_sel = alu_of_funct3(w_f3);
            end else if (w_f7 == F7_ALT && w_f3 == 3'd0) begin
               w_b.alu_sel = ALU_SUB;
            end else if (w_f7 == F7_ALT && w_f3 == 3'd5) begin
               w_b.alu_sel = ALU_SRA;
            end else if (w_f7 == F7_MULDIV && ENABLE_M) begin
               w_b.alu_sel = ALU_MUL | {2'b00, w_f3};
               w_b.is_mdu  = 1'b1;
            end else begin
               w_legal = 1'b0;
            end
         end
         default: w_legal = 1'b0;
      endcase
      // Illegal encodings issue a side-effect-free bundle carrying only the raw register fields.
      if (!w_legal) begin
         w_b         = '0;
         w_b.rs1     = i_instruction[19:15];
         w_b.rs2     = i_instruction[24:20];
         w_b.rd      = i_instruction[11:7];
         w_b.illegal = 1'b1;
         w_u1        = 1'b0;
         w_u2        = 1'b0;
      end
   end

   assign o_bundle   = w_b;
   assign o_uses_rs1 = w_u1;
   assign o_uses_rs2 = w_u2;

endmodule

// File: rtl/pipelined_control_unit.sv
// rtl/pipelined_control_unit.sv - registered decode/control stage with handshake, hazard and MDU stall
module pipelined_control_unit
   import rv_ctrl_pkg::*;
#(
   parameter int ENABLE_M    = 0,
   parameter int MDU_LATENCY = 4,
   parameter int ALU_SEL_W   = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          instruction,
   input  logic                 flush,
   input  logic                 ex_load_valid,
   input  logic [4:0]           ex_load_rd,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [4:0]           rs1,
   output logic [4:0]           rs2,
   output logic [4:0]           rd,
   output logic [2:0]           immediate_select,
   output logic                 a_select,
   output logic                 b_select,
   output logic [ALU_SEL_W-1:0] alu_select,
   output logic                 register_write_enable,
   output logic [3:0]           memory_write_enable,
   output logic [2:0]           memory_split_option,
   output logic [1:0]           write_back_select,
   output logic                 is_branch,
   output logic                 is_jump,
   output logic [2:0]           branch_type,
   output logic                 is_load,
   output logic                 is_mdu,
   output logic                 illegal
);

   localparam int                BUSY_W    = $clog2(MDU_LATENCY + 1);
   localparam logic [BUSY_W-1:0] BUSY_LOAD = BUSY_W'(MDU_LATENCY);

   ctrl_bundle_t      w_dec;
   ctrl_bundle_t      r_bundle;
   logic              w_uses_rs1;
   logic              w_uses_rs2;
   logic              w_hazard;
   logic              w_accept;
   logic              r_out_valid;
   logic [BUSY_W-1:0] r_busy;

   rv_decode_comb #(
      .ENABLE_M (ENABLE_M != 0)
   ) u_decode (
      .i_instruction (instruction),
      .o_bundle      (w_dec),
      .o_uses_rs1    (w_uses_rs1),
      .o_uses_rs2    (w_uses_rs2)
   );

   // A consumer of a load still in execute must wait one cycle for the data.
   assign w_hazard = ex_load_valid && (ex_load_rd != 5'd0) &&
                     ((w_uses_rs1 && (w_dec.rs1 == ex_load_rd)) ||
                      (w_uses_rs2 && (w_dec.rs2 == ex_load_rd)));

   assign in_ready = rst_n && !flush && !w_hazard && (r_busy == '0) &&
                     (!r_out_valid || out_ready);
   assign w_accept = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_bundle    <= '0;
         r_busy      <= '0;
      end else begin
         // The divider is not pipelined, so the counter runs down even across a flush.
         if (w_accept && w_dec.is_mdu) begin
            r_busy <= BUSY_LOAD;
         end else if (r_busy != '0) begin
            r_busy <= r_busy - BUSY_W'(1);
         end
         if (flush) begin
            r_out_valid <= 1'b0;
         end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_bundle    <= w_dec;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_valid             = r_out_valid;
   assign rs1                   = r_bundle.rs1;
   assign rs2                   = r_bundle.rs2;
   assign rd                    = r_bundle.rd;
   assign immediate_select      = r_bundle.imm_sel;
   assign a_select              = r_bundle.a_sel;
   assign b_select              = r_bundle.b_sel;
   assign alu_select            = r_bundle.alu_sel[ALU_SEL_W-1:0];
   assign register_write_enable = r_bundle.rwe;
   assign memory_write_enable   = r_bundle.mwe;
   assign memory_split_option   = r_bundle.split;
   assign write_back_select     = r_bundle.wb_sel;
   assign is_branch             = r_bundle.is_branch;
   assign is_jump               = r_bundle.is_jump;
   assign branch_type           = r_bundle.branch_type;
   assign is_load               = r_bundle.is_load;
   assign is_mdu                = r_bundle.is_mdu;
   assign illegal               = r_bundle.illegal;

endmodule
